sprite_line_scanner: RTL and testbench

- Per-scanline sequencer for the sprite attribute RAM: on each line start it walks sprite entries 0..NUM_SPRITES-1 through the RAM's registered read port.
- It decodes each 48-bit attribute word and tests vertical coverage of the requested line.
- Each visible sprite goes out on a valid/ready stream to the sprite line renderer, together with the sprite row to fetch.
- Enforces a per-line sprite budget and reports overflow; sits between the video timing generator and the sprite renderer.

---
 rtl/sprite_pkg.sv | 47 ++++
 rtl/sprite_line_scanner_if.sv | 31 +++
 rtl/sprite_hit_eval.sv | 28 ++
 rtl/sprite_line_scanner.sv | 146 ++++++++++++++
 tb/tb_sprite_line_scanner.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line scanner: attribute word layout,
// scan FSM encoding and the height-code decode.
package sprite_pkg;

    localparam int SPRITE_IDX_W = 8;
    localparam int LINE_W       = 9;
    localparam int ATTR_W       = 48;
    localparam int ROW_W        = 6;

    localparam int X_LSB      = 0;
    localparam int X_MSB      = 9;
    localparam int VFLIP_BIT  = 10;
    localparam int HFLIP_BIT  = 11;
    localparam int PAL_LSB    = 12;
    localparam int PAL_MSB    = 15;
    localparam int Y_LSB      = 16;
    localparam int Y_MSB      = 24;
    localparam int MODE_BIT   = 25;
    localparam int Z_LSB      = 26;
    localparam int Z_MSB      = 27;
    localparam int HEIGHT_LSB = 28;
    localparam int HEIGHT_MSB = 29;
    localparam int WIDTH_LSB  = 30;
    localparam int WIDTH_MSB  = 31;
    localparam int ADDR_LSB   = 32;
    localparam int ADDR_MSB   = 47;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EVAL,
        ST_OUT,
        ST_DONE
    } scan_state_e;

    function automatic logic [6:0] height_rows(input logic [1:0] code);
        logic [6:0] rows;
        unique case (code)
            2'd0:    rows = 7'd8;
            2'd1:    rows = 7'd16;
            2'd2:    rows = 7'd32;
            default: rows = 7'd64;
        endcase
        return rows;
    endfunction

endpackage

// File: rtl/sprite_line_scanner_if.sv
// Attribute RAM read port plus the visible-sprite record stream toward the
// line renderer. master = scanner side.
interface sprite_line_scanner_if
    import sprite_pkg::*;
;
    logic                    ram_rd_en_o;
    logic [SPRITE_IDX_W-1:0] ram_rd_addr_o;
    logic [ATTR_W-1:0]       ram_rd_data_i;

    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [ATTR_W-1:0]       out_attr_o;
    logic [SPRITE_IDX_W-1:0] out_index_o;
    logic [ROW_W-1:0]        out_row_o;

    modport master (
        output ram_rd_en_o, ram_rd_addr_o,
        input  ram_rd_data_i,
        output out_valid_o,
        input  out_ready_i,
        output out_attr_o, out_index_o, out_row_o
    );

    modport slave (
        input  ram_rd_en_o, ram_rd_addr_o,
        output ram_rd_data_i,
        input  out_valid_o,
        output out_ready_i,
        input  out_attr_o, out_index_o, out_row_o
    );
endinterface

// File: rtl/sprite_hit_eval.sv
// Vertical coverage test of one attribute word against a scanline; also
// produces the sprite row to fetch with vertical flip applied.
module sprite_hit_eval
    import sprite_pkg::*;
(
    input  logic [ATTR_W-1:0] attr,
    input  logic [LINE_W-1:0] line,
    output logic              hit,
    output logic [ROW_W-1:0]  row
);
    logic [LINE_W-1:0] diff;
    logic [6:0]        rows;
    logic [ROW_W-1:0]  mask;
    logic [ROW_W-1:0]  raw_row;
    logic              unused_fields;

    // 9-bit wrap makes sprites straddling line 511 -> 0 visible at the top
    assign diff    = line - attr[Y_MSB:Y_LSB];
    assign rows    = height_rows(attr[HEIGHT_MSB:HEIGHT_LSB]);
    assign mask    = ROW_W'(rows - 7'd1);
    assign raw_row = diff[ROW_W-1:0] & mask;

    assign hit = (attr[Z_MSB:Z_LSB] != 2'b00) && (diff < LINE_W'(rows));
    assign row = attr[VFLIP_BIT] ? (mask - raw_row) : raw_row;

    assign unused_fields = ^{attr[ATTR_W-1:HEIGHT_MSB+1], attr[Z_LSB-1:Y_MSB+1],
                             attr[Y_LSB-1:VFLIP_BIT+1], attr[VFLIP_BIT-1:0]};
endmodule

// File: rtl/sprite_line_scanner.sv
// Per-scanline walk of the sprite attribute RAM, emitting each visible sprite
// (with its row) to the renderer under a per-line budget.
//
// state | meaning
// IDLE  | waiting for line_start_i
// READ  | read enable for entry index
// EVAL  | RAM data valid, coverage test
// OUT   | record presented, waiting for out_ready_i
// DONE  | one-cycle done_o pulse
module sprite_line_scanner
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES  = 128,
    parameter int MAX_PER_LINE = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  line_start_i,
    input  logic [LINE_W-1:0]     line_i,
    input  logic                  sprites_enable_i,
    sprite_line_scanner_if.master bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o
);
    localparam logic [SPRITE_IDX_W-1:0] LAST_IDX = SPRITE_IDX_W'(NUM_SPRITES - 1);
    localparam logic [7:0]              MAX_CNT  = 8'(MAX_PER_LINE);

    scan_state_e             state_q, state_d;
    logic [SPRITE_IDX_W-1:0] index_q;
    logic [7:0]              count_q;
    logic [LINE_W-1:0]       line_q;
    logic [ATTR_W-1:0]       out_attr_q;
    logic [SPRITE_IDX_W-1:0] out_index_q;
    logic [ROW_W-1:0]        out_row_q;
    logic                    overflow_q;
    logic                    hit;
    logic [ROW_W-1:0]        row;
    logic                    last_entry;
    logic                    budget_left;

    sprite_hit_eval u_hit_eval (
        .attr (bus.ram_rd_data_i),
        .line (line_q),
        .hit  (hit),
        .row  (row)
    );

    assign last_entry  = (index_q == LAST_IDX);
    assign budget_left = (count_q < MAX_CNT);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // line_start_i restarts the scan from any state, dropping a pending record
    always_comb begin
        state_d = state_q;
        if (line_start_i) begin
            state_d = sprites_enable_i ? ST_READ : ST_DONE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_READ: state_d = ST_EVAL;
                ST_EVAL: begin
                    if (hit)             state_d = budget_left ? ST_OUT : ST_DONE;
                    else if (last_entry) state_d = ST_DONE;
                    else                 state_d = ST_READ;
                end
                ST_OUT: begin
                    if (bus.out_ready_i) state_d = last_entry ? ST_DONE : ST_READ;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ram_rd_en_o   = 1'b0;
        bus.ram_rd_addr_o = '0;
        bus.out_valid_o   = 1'b0;
        busy_o            = 1'b0;
        done_o            = 1'b0;
        unique case (state_q)
            ST_READ: begin
                bus.ram_rd_en_o   = 1'b1;
                bus.ram_rd_addr_o = index_q;
                busy_o            = 1'b1;
            end
            ST_EVAL: busy_o = 1'b1;
            ST_OUT: begin
                bus.out_valid_o = 1'b1;
                busy_o          = 1'b1;
            end
            ST_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            index_q     <= '0;
            count_q     <= '0;
            line_q      <= '0;
            out_attr_q  <= '0;
            out_index_q <= '0;
            out_row_q   <= '0;
            overflow_q  <= 1'b0;
        end else if (line_start_i) begin
            index_q    <= '0;
            count_q    <= '0;
            line_q     <= line_i;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_EVAL: begin
                    if (hit) begin
                        if (budget_left) begin
                            out_attr_q  <= bus.ram_rd_data_i;
                            out_index_q <= index_q;
                            out_row_q   <= row;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end else if (!last_entry) begin
                        index_q <= index_q + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready_i) begin
                        count_q <= count_q + 1'b1;
                        if (!last_entry) index_q <= index_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_attr_o  = out_attr_q;
    assign bus.out_index_o = out_index_q;
    assign bus.out_row_o   = out_row_q;
    assign overflow_o      = overflow_q;
endmodule

// File: tb/tb_sprite_line_scanner.sv
// Randomized and directed bench for sprite_line_scanner against a line-level
// reference model; a second instance runs with a budget of 4 sprites per line.
module tb_sprite_line_scanner;
    import sprite_pkg::*;

    localparam int NUM = 128;

    typedef struct {
        int          idx;
        int          row;
        logic [47:0] attr;
    } rec_t;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       line_start_i;
    logic [8:0] line_i;
    logic       sprites_enable_i;
    logic       busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic       sel;
    logic       ready_drv;

    logic [47:0] mem [0:255];
    rec_t        exp_q[$];
    int          exp_scanned;
    bit          exp_ovf;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk_i = ~clk_i;

    sprite_line_scanner_if bus_a ();
    sprite_line_scanner_if bus_b ();

    sprite_line_scanner #(.NUM_SPRITES(NUM), .MAX_PER_LINE(64)) dut_a (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .line_start_i(line_start_i), .line_i(line_i),
        .sprites_enable_i(sprites_enable_i), .bus(bus_a),
        .busy_o(busy_a), .done_o(done_a), .overflow_o(ovf_a));

    sprite_line_scanner #(.NUM_SPRITES(NUM), .MAX_PER_LINE(4)) dut_b (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .line_start_i(line_start_i), .line_i(line_i),
        .sprites_enable_i(sprites_enable_i), .bus(bus_b),
        .busy_o(busy_b), .done_o(done_b), .overflow_o(ovf_b));

    always @(posedge clk_i) begin
        if (bus_a.ram_rd_en_o) bus_a.ram_rd_data_i <= mem[bus_a.ram_rd_addr_o];
        if (bus_b.ram_rd_en_o) bus_b.ram_rd_data_i <= mem[bus_b.ram_rd_addr_o];
    end

    assign bus_a.out_ready_i = sel ? 1'b1 : ready_drv;
    assign bus_b.out_ready_i = sel ? ready_drv : 1'b1;

    logic        s_rd_en, s_valid, s_busy, s_done, s_ovf;
    logic [7:0]  s_rd_addr, s_index;
    logic [5:0]  s_row;
    logic [47:0] s_attr;
    assign s_rd_en   = sel ? bus_b.ram_rd_en_o   : bus_a.ram_rd_en_o;
    assign s_rd_addr = sel ? bus_b.ram_rd_addr_o : bus_a.ram_rd_addr_o;
    assign s_valid   = sel ? bus_b.out_valid_o   : bus_a.out_valid_o;
    assign s_index   = sel ? bus_b.out_index_o   : bus_a.out_index_o;
    assign s_row     = sel ? bus_b.out_row_o     : bus_a.out_row_o;
    assign s_attr    = sel ? bus_b.out_attr_o    : bus_a.out_attr_o;
    assign s_busy    = sel ? busy_b : busy_a;
    assign s_done    = sel ? done_b : done_a;
    assign s_ovf     = sel ? ovf_b  : ovf_a;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] make_attr(input int y, input int hcode, input int z, input bit vflip);
        logic [47:0] a;
        a = 48'({$urandom(), $urandom()});
        a[24:16] = 9'(y);
        a[29:28] = 2'(hcode);
        a[27:26] = 2'(z);
        a[10]    = vflip;
        return a;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 48'd0;
    endtask

    // Reference: which entries are visible on this line, in scan order, cut at the budget
    task automatic model_scan(input logic [8:0] line, input bit en, input int max_cnt);
        int y, h, diff;
        exp_q.delete();
        exp_scanned = 0;
        exp_ovf     = 0;
        if (!en) return;
        for (int i = 0; i < NUM; i++) begin
            rec_t r;
            y    = int'(mem[i][24:16]);
            h    = 8 << mem[i][29:28];
            diff = (int'(line) - y + 512) % 512;
            exp_scanned++;
            if (mem[i][27:26] != 2'd0 && diff < h) begin
                if (exp_q.size() == max_cnt) begin
                    exp_ovf = 1;
                    break;
                end
                r.idx  = i;
                r.row  = mem[i][10] ? (h - 1 - diff) : diff;
                r.attr = mem[i];
                exp_q.push_back(r);
            end
        end
    endtask

    // Two cycles per entry examined, one per emitted record plus its stall, one for DONE
    function automatic int scan_len(input bit en, input int st0, input int stn);
        int n;
        if (!en) return 1;
        n = 2 * exp_scanned + 1;
        foreach (exp_q[k]) n += 1 + ((k == 0) ? st0 : stn);
        return n;
    endfunction

    task automatic run_scan(input logic [8:0] line, input bit en, input int st0, input int stn,
                            input int abort_at, input logic [8:0] abort_line);
        int   max_cnt, cyc, start_cyc, exp_done, done_cnt, reads, wait_cnt, rec_no, cur_stall;
        bit   cur_en;
        rec_t r;
        max_cnt = sel ? 4 : 64;
        model_scan(line, en, max_cnt);
        exp_done  = scan_len(en, st0, stn);
        cyc       = 0;
        start_cyc = 0;
        done_cnt  = 0;
        reads     = 0;
        wait_cnt  = 0;
        rec_no    = 0;
        cur_en    = en;
        @(negedge clk_i);
        line_i           = line;
        sprites_enable_i = en;
        line_start_i     = 1'b1;
        ready_drv        = 1'b0;
        while (cyc < exp_done + 3) begin
            @(negedge clk_i);
            cyc++;
            line_start_i = 1'b0;
            if (cyc == start_cyc + 1) begin
                check("busy_start", s_busy, cur_en);
                check("ovf_clear", s_ovf, 0);
            end
            check("rd_addr", s_rd_addr, s_rd_en ? reads : 0);
            if (s_rd_en) reads++;
            if (s_done) begin
                done_cnt++;
                check("done_cycle", cyc, exp_done);
            end
            if (s_valid) begin
                cur_stall = (rec_no == 0) ? st0 : stn;
                if (exp_q.size() == 0) begin
                    check("extra_record", 1, 0);
                    ready_drv = 1'b1;
                end else begin
                    r = exp_q[0];
                    check("out_index", s_index, r.idx);
                    check("out_row", s_row, r.row);
                    check("out_attr", s_attr, r.attr);
                    if (wait_cnt >= cur_stall) begin
                        ready_drv = 1'b1;
                        void'(exp_q.pop_front());
                        wait_cnt = 0;
                        rec_no++;
                    end else begin
                        ready_drv = 1'b0;
                        wait_cnt++;
                    end
                end
            end else begin
                ready_drv = 1'($urandom_range(0, 1));
            end
            if (abort_at != 0 && cyc == abort_at) begin
                line_i           = abort_line;
                sprites_enable_i = 1'b1;
                line_start_i     = 1'b1;
                ready_drv        = 1'b0;
                model_scan(abort_line, 1'b1, max_cnt);
                exp_done  = abort_at + scan_len(1'b1, st0, stn);
                start_cyc = abort_at;
                reads     = 0;
                wait_cnt  = 0;
                rec_no    = 0;
                cur_en    = 1'b1;
            end
        end
        check("done_count", done_cnt, 1);
        check("records_left", exp_q.size(), 0);
        check("reads", reads, exp_scanned);
        check("overflow", s_ovf, exp_ovf);
        check("busy_end", s_busy, 0);
    endtask

    initial begin
        rst_n_i          = 1'b0;
        line_start_i     = 1'b0;
        line_i           = 9'd0;
        sprites_enable_i = 1'b0;
        sel              = 1'b0;
        ready_drv        = 1'b0;
        clear_mem();
        #1;
        check("rst_valid", bus_a.out_valid_o, 0);
        check("rst_rd_en", bus_a.ram_rd_en_o, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_attr", bus_a.out_attr_o, 0);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;

        mem[1] = make_attr(3, 1, 1, 0);
        run_scan(9'd3, 1, 0, 0, 0, 9'd0);
        run_scan(9'd18, 1, 1, 0, 0, 9'd0);
        run_scan(9'd19, 1, 0, 0, 0, 9'd0);
        mem[1][10] = 1'b1;
        run_scan(9'd4, 1, 2, 0, 0, 9'd0);
        mem[1][27:26] = 2'd0;
        run_scan(9'd4, 1, 0, 0, 0, 9'd0);

        clear_mem();
        mem[5] = make_attr(510, 0, 2, 0);
        run_scan(9'd2, 1, 0, 0, 0, 9'd0);
        run_scan(9'd6, 1, 0, 0, 0, 9'd0);

        clear_mem();
        mem[1]  = make_attr(3, 1, 1, 0);
        mem[10] = make_attr(0, 2, 3, 1);
        run_scan(9'd3, 1, 5, 0, 0, 9'd0);
        run_scan(9'd3, 0, 0, 0, 0, 9'd0);
        run_scan(9'd3, 1, 3, 1, 40, 9'd300);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = 48'({$urandom(), $urandom()});
            sel = 1'(t % 3 == 2);
            run_scan(9'($urandom_range(0, 511)), 1'($urandom_range(0, 9) != 0),
                     $urandom_range(0, 3), $urandom_range(0, 2), 0, 9'd0);
        end

        sel = 1'b1;
        clear_mem();
        mem[3]   = make_attr(100, 3, 1, 0);
        mem[7]   = make_attr(100, 3, 2, 1);
        mem[20]  = make_attr(100, 3, 3, 0);
        mem[50]  = make_attr(100, 3, 1, 1);
        mem[90]  = make_attr(100, 3, 1, 0);
        mem[120] = make_attr(100, 3, 2, 0);
        run_scan(9'd110, 1, 1, 0, 0, 9'd0);
        run_scan(9'd400, 1, 0, 0, 0, 9'd0);

        sel = 1'b0;
        clear_mem();
        mem[1] = make_attr(3, 1, 1, 0);
        @(negedge clk_i);
        line_i           = 9'd3;
        sprites_enable_i = 1'b1;
        line_start_i     = 1'b1;
        ready_drv        = 1'b0;
        @(negedge clk_i);
        line_start_i = 1'b0;
        for (int k = 0; k < 20 && !bus_a.out_valid_o; k++) @(negedge clk_i);
        check("rst_pre_valid", bus_a.out_valid_o, 1);
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_mid_valid", bus_a.out_valid_o, 0);
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_rd_en", bus_a.ram_rd_en_o, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("rst_mid_done", done_a, 0);
        end
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("post_rst_busy", busy_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
